// File: rtl/serial_deserializer.sv
// serial_deserializer: receive side of the serial link. Shifts an MSB-first
// bitstream into N-bit words and hands each word to the consumer through a
// one-entry valid/ready output buffer. It raises one-cycle pulses for overrun
// (a word was dropped), framing errors (a restart mid-frame) and, optionally,
// parity errors.
// Optional feature: define DESER_PARITY_EN to expect one even-parity bit after
// each word. Without it, a frame is N data bits and o_parity_err is tied to 0.
module serial_deserializer #(
   parameter int N = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_serial_in,
   input  logic         i_bit_valid,
   input  logic         i_frame_sync,
   output logic [N-1:0] o_parallel_out,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic         o_busy,
   output logic         o_overrun,
   output logic         o_frame_err,
   output logic         o_parity_err
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV
`ifdef DESER_PARITY_EN
      ,ST_PAR
`endif
   } state_t;

   state_t         r_state;
   logic [CW-1:0]  r_cnt;
   logic [N-2:0]   r_shreg;
   logic [N-1:0]   r_parallel_out;
   logic           r_out_valid;
   logic           r_busy;
   logic           r_overrun;
   logic           r_frame_err;
`ifdef DESER_PARITY_EN
   logic [N-1:0]   r_word;
   logic           r_parity_err;
`endif

   logic [N-2:0]   w_shift;
   logic [N-1:0]   w_word;
   logic [N-1:0]   w_commit_word;
   logic           w_restart;
   logic           w_commit;
   logic           w_parity_bad;
   logic           w_consume;
   logic           w_can_load;

   // Shift register contents after taking in the current bit. With N=2 the
   // register is a single bit, so there is nothing older to keep.
   generate
      if (N > 2) begin : g_shift_wide
         assign w_shift = {r_shreg[N-3:0], i_serial_in};
      end else begin : g_shift_narrow
         assign w_shift = i_serial_in;
      end
   endgenerate

   // The final data bit completes the word without passing through the register.
   assign w_word     = {r_shreg, i_serial_in};
   assign w_consume  = r_out_valid & i_out_ready;
   // The buffer can take a new word if it is empty or is being drained on this edge.
   assign w_can_load = ~r_out_valid | i_out_ready;

   // Work out what the current bit does: restart, commit, or parity failure.
   always_comb begin
      w_restart     = 1'b0;
      w_commit      = 1'b0;
      w_commit_word = w_word;
      w_parity_bad  = 1'b0;
      if (i_bit_valid) begin
         case (r_state)
            ST_RECV: begin
               if (i_frame_sync) begin
                  w_restart = 1'b1;
               end else if (r_cnt == CNT_LAST) begin
`ifndef DESER_PARITY_EN
                  w_commit = 1'b1;
`endif
               end
            end
`ifdef DESER_PARITY_EN
            ST_PAR: begin
               if (i_frame_sync) begin
                  w_restart = 1'b1;
               end else if (^{r_word, i_serial_in}) begin
                  w_parity_bad = 1'b1;
               end else begin
                  w_commit      = 1'b1;
                  w_commit_word = r_word;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // Frame FSM, output buffer and registered status/error pulses.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         r_shreg        <= '0;
         r_parallel_out <= '0;
         r_out_valid    <= 1'b0;
         r_busy         <= 1'b0;
         r_overrun      <= 1'b0;
         r_frame_err    <= 1'b0;
`ifdef DESER_PARITY_EN
         r_word         <= '0;
         r_parity_err   <= 1'b0;
`endif
      end else begin
         r_overrun   <= w_commit & ~w_can_load;
         r_frame_err <= w_restart;
`ifdef DESER_PARITY_EN
         r_parity_err <= w_parity_bad;
`endif

         // A commit loads the buffer; a consume alone empties it.
         if (w_commit && w_can_load) begin
            r_parallel_out <= w_commit_word;
            r_out_valid    <= 1'b1;
         end else if (w_consume) begin
            r_out_valid <= 1'b0;
         end

         if (i_bit_valid) begin
            if (i_frame_sync) begin
               // First bit of a frame, whether from IDLE or as a restart.
               r_shreg <= w_shift;
               r_cnt   <= CW'(1);
               r_state <= ST_RECV;
               r_busy  <= 1'b1;
            end else begin
               case (r_state)
                  ST_RECV: begin
                     if (r_cnt != CNT_LAST) begin
                        r_shreg <= w_shift;
                        r_cnt   <= r_cnt + 1'b1;
                     end else begin
`ifdef DESER_PARITY_EN
                        r_word  <= w_word;
                        r_state <= ST_PAR;
`else
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
`endif
                     end
                  end
`ifdef DESER_PARITY_EN
                  ST_PAR: begin
                     r_cnt   <= '0;
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
`endif
                  default: ;
               endcase
            end
         end
      end
   end

   assign o_parallel_out = r_parallel_out;
   assign o_out_valid    = r_out_valid;
   assign o_busy         = r_busy;
   assign o_overrun      = r_overrun;
   assign o_frame_err    = r_frame_err;
`ifdef DESER_PARITY_EN
   assign o_parity_err   = r_parity_err;
`else
   assign o_parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed testbench for serial_deserializer (N=8). Each check is an
// immediate assertion; a frame gets its even-parity bit when DESER_PARITY_EN
// is defined.
module tb_serial_deserializer;

   localparam int N = 8;

   logic         clk;
   logic         rst_n;
   logic         serial_in;
   logic         bit_valid;
   logic         frame_sync;
   logic [N-1:0] parallel_out;
   logic         out_valid;
   logic         out_ready;
   logic         busy;
   logic         overrun;
   logic         frame_err;
   logic         parity_err;

   int n_vec;
   int n_err;
   int ferr_seen;
   int ovr_seen;

   serial_deserializer #(.N(N)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_serial_in    (serial_in),
      .i_bit_valid    (bit_valid),
      .i_frame_sync   (frame_sync),
      .o_parallel_out (parallel_out),
      .o_out_valid    (out_valid),
      .i_out_ready    (out_ready),
      .o_busy         (busy),
      .o_overrun      (overrun),
      .o_frame_err    (frame_err),
      .o_parity_err   (parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One bit on one edge; outputs are sampled 1 time unit after that edge.
   task automatic send_bit(input logic b, input logic fs);
      serial_in  = b;
      frame_sync = fs;
      bit_valid  = 1'b1;
      @(posedge clk);
      #1;
      bit_valid  = 1'b0;
      frame_sync = 1'b0;
      ferr_seen += int'(frame_err);
      ovr_seen  += int'(overrun);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Full frame MSB first; out_ready is raised only on the final edge.
   task automatic send_word(input logic [7:0] w, input int gap_max, input logic rdy_last);
      for (int i = 7; i >= 0; i--) begin
         if (gap_max > 0) idle_cycles(int'($urandom_range(0, gap_max)));
`ifdef DESER_PARITY_EN
         out_ready = 1'b0;
`else
         out_ready = (i == 0) ? rdy_last : 1'b0;
`endif
         send_bit(w[i], i == 7);
      end
`ifdef DESER_PARITY_EN
      out_ready = rdy_last;
      send_bit(^w, 1'b0);
`endif
      out_ready = 1'b0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      int f0;
      int o0;
      n_vec = 0;
      n_err = 0;
      ferr_seen = 0;
      ovr_seen = 0;
      rst_n = 1'b0;
      serial_in = 1'b0;
      bit_valid = 1'b0;
      frame_sync = 1'b0;
      out_ready = 1'b0;

      // Reset state
      idle_cycles(2);
      chk("rst_parallel_out", 32'(parallel_out), 32'h00);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_flags", {29'd0, overrun, frame_err, parity_err}, 32'd0);
      rst_n = 1'b1;
      idle_cycles(1);

      // Basic frame 0xA5
      send_word(8'hA5, 0, 1'b0);
      chk("basic_out_valid", 32'(out_valid), 32'd1);
      chk("basic_parallel_out", 32'(parallel_out), 32'hA5);
      chk("basic_busy", 32'(busy), 32'd0);
      chk("basic_no_overrun", 32'(overrun), 32'd0);
      $display("frame 0xA5 sent: out=%02h valid=%0d", parallel_out, out_valid);

      // Overrun: buffer full, consumer not ready
      send_word(8'h3C, 0, 1'b0);
      chk("ovr_pulse", 32'(overrun), 32'd1);
      chk("ovr_parallel_out_kept", 32'(parallel_out), 32'hA5);
      chk("ovr_out_valid", 32'(out_valid), 32'd1);
      idle_cycles(1);
      chk("ovr_pulse_one_cycle", 32'(overrun), 32'd0);
      $display("frame 0x3C overrun: out=%02h", parallel_out);

      // Commit and consume on the same edge
      o0 = ovr_seen;
      send_word(8'h3C, 0, 1'b1);
      chk("swap_parallel_out", 32'(parallel_out), 32'h3C);
      chk("swap_out_valid", 32'(out_valid), 32'd1);
      chk("swap_no_overrun", 32'(ovr_seen - o0), 32'd0);
      consume();
      chk("consume_out_valid", 32'(out_valid), 32'd0);
      chk("consume_out_held", 32'(parallel_out), 32'h3C);
      $display("frame 0x3C swapped in and consumed");

      // Restart after 3 bits, then 0x0F
      f0 = ferr_seen;
      send_bit(1'b1, 1'b1);
      chk("start_no_frame_err", 32'(frame_err), 32'd0);
      chk("start_busy", 32'(busy), 32'd1);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_word(8'h0F, 0, 1'b0);
      chk("restart_frame_err_once", 32'(ferr_seen - f0), 32'd1);
      chk("restart_parallel_out", 32'(parallel_out), 32'h0F);
      chk("restart_out_valid", 32'(out_valid), 32'd1);
      consume();
      $display("restart: frame_err pulses=%0d out=%02h", ferr_seen - f0, parallel_out);

      // Stray bit in IDLE, then a gapped frame 0x96
      send_bit(1'b1, 1'b0);
      chk("stray_busy", 32'(busy), 32'd0);
      chk("stray_no_frame_err", 32'(frame_err), 32'd0);
      chk("stray_out_valid", 32'(out_valid), 32'd0);
      send_word(8'h96, 3, 1'b0);
      chk("gap_parallel_out", 32'(parallel_out), 32'h96);
      chk("gap_out_valid", 32'(out_valid), 32'd1);
      $display("gapped frame 0x96: out=%02h", parallel_out);

      // Reset mid-frame with a word still buffered
      send_bit(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
      chk("mid_busy_before_rst", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_parallel_out", 32'(parallel_out), 32'h00);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      idle_cycles(1);
      rst_n = 1'b1;
      idle_cycles(1);
      chk("post_rst_flags", {29'd0, overrun, frame_err, parity_err}, 32'd0);
      f0 = ferr_seen;
      send_word(8'h5A, 0, 1'b0);
      chk("post_rst_parallel_out", 32'(parallel_out), 32'h5A);
      chk("post_rst_out_valid", 32'(out_valid), 32'd1);
      chk("post_rst_no_frame_err", 32'(ferr_seen - f0), 32'd0);
      chk("post_rst_parity_err", 32'(parity_err), 32'd0);
      consume();
      $display("reset mid-frame, then frame 0x5A: out=%02h", parallel_out);

`ifdef DESER_PARITY_EN
      // 0x07 with good parity bit 1, then with bad parity bit 0
      send_word(8'h07, 0, 1'b0);
      chk("par_good_out", 32'(parallel_out), 32'h07);
      chk("par_good_valid", 32'(out_valid), 32'd1);
      chk("par_good_no_err", 32'(parity_err), 32'd0);
      consume();
      send_bit(1'b0, 1'b1);
      for (int i = 6; i >= 0; i--) send_bit(i < 3, 1'b0);
      send_bit(1'b0, 1'b0);
      chk("par_bad_pulse", 32'(parity_err), 32'd1);
      chk("par_bad_valid", 32'(out_valid), 32'd0);
      chk("par_bad_busy", 32'(busy), 32'd0);
      idle_cycles(1);
      chk("par_bad_one_cycle", 32'(parity_err), 32'd0);
      $display("parity: good 0x07 accepted, bad 0x07 dropped");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
